// File: rtl/vliw_bundle_packer_pkg.sv
// Shared VLIW encoding constants: slot indices, opcodes, NOP word.
// Also used by the core's decode stage.
package vliw_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 32;
    localparam int PKT_W     = 256;
    localparam int OPC_W     = 5;

    localparam logic [4:0] OPC_ADD      = 5'b00000;
    localparam logic [4:0] OPC_SBC      = 5'b00011;
    localparam logic [4:0] OPC_MUL      = 5'b00100;
    localparam logic [4:0] OPC_FADD     = 5'b00101;
    localparam logic [4:0] OPC_FMUL     = 5'b00110;
    localparam logic [4:0] OPC_LOGIC_LO = 5'b01000;
    localparam logic [4:0] OPC_LOGIC_HI = 5'b01111;
    localparam logic [4:0] OPC_LDR      = 5'b10010;
    localparam logic [4:0] OPC_STR      = 5'b10011;
    localparam logic [4:0] OPC_MOV      = 5'b10100;

    localparam logic [2:0] SLOT_ALU   = 3'd0;
    localparam logic [2:0] SLOT_MUL   = 3'd1;
    localparam logic [2:0] SLOT_FADD  = 3'd2;
    localparam logic [2:0] SLOT_FMUL  = 3'd3;
    localparam logic [2:0] SLOT_LOGIC = 3'd4;
    localparam logic [2:0] SLOT_LDR   = 3'd5;
    localparam logic [2:0] SLOT_STR   = 3'd6;
    localparam logic [2:0] SLOT_MOV   = 3'd7;

    // ADD r0,r0,r0 with r0 hardwired to zero
    localparam logic [SLOT_W-1:0] NOP_WORD = 32'h0;

    typedef logic [NUM_SLOTS-1:0][SLOT_W-1:0] slots_t;
    typedef logic [NUM_SLOTS-1:0]             occ_t;

    // Slot 0 lands in the MSBs; empty slots become NOP.
    function automatic logic [PKT_W-1:0] pack_bundle(
        input slots_t s,
        input occ_t   occ
    );
        logic [PKT_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            p[PKT_W-1-SLOT_W*i -: SLOT_W] = occ[i] ? s[i] : NOP_WORD;
        end
        return p;
    endfunction

endpackage

// File: rtl/vliw_bundle_packer_if.sv
// Instruction input stream and packet output port of the packer.
// master = producer/sink side, slave = packer side.
interface vliw_bundle_packer_if;
    import vliw_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [SLOT_W-1:0] in_data;
    logic              flush;
    logic              pkt_valid;
    logic              pkt_ready;
    logic [PKT_W-1:0]  pkt_data;
    logic [31:0]       pkt_addr;
    logic              err_illegal;

    modport master (
        output in_valid, in_data, flush, pkt_ready,
        input  in_ready, pkt_valid, pkt_data, pkt_addr, err_illegal
    );

    modport slave (
        input  in_valid, in_data, flush, pkt_ready,
        output in_ready, pkt_valid, pkt_data, pkt_addr, err_illegal
    );

endinterface

// File: rtl/vliw_bundle_packer_classifier.sv
// Opcode to functional-unit slot decode.
// Purely combinational; unmapped opcodes report legal_o = 0.
module vliw_slot_classifier
    import vliw_pkg::*;
(
    input  logic [OPC_W-1:0] opc_i,
    output logic             legal_o,
    output logic [2:0]       slot_o
);

    // Map each opcode group onto its slot
    always_comb begin
        legal_o = 1'b1;
        slot_o  = SLOT_ALU;
        case (opc_i) inside
            [OPC_ADD:OPC_SBC]:           slot_o = SLOT_ALU;
            OPC_MUL:                     slot_o = SLOT_MUL;
            OPC_FADD:                    slot_o = SLOT_FADD;
            OPC_FMUL:                    slot_o = SLOT_FMUL;
            [OPC_LOGIC_LO:OPC_LOGIC_HI]: slot_o = SLOT_LOGIC;
            OPC_LDR:                     slot_o = SLOT_LDR;
            OPC_STR:                     slot_o = SLOT_STR;
            OPC_MOV:                     slot_o = SLOT_MOV;
            default:                     legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/vliw_bundle_packer.sv
// Packs a serial instruction stream into 8-slot VLIW bundles
// and writes them with a wrapping instruction-memory index.
module vliw_bundle_packer
    import vliw_pkg::*;
#(
    parameter int INST_MEM_SIZE = 1024,
    parameter int MAX_WAIT      = 16
) (
    input logic                 clk,
    input logic                 rst,
    vliw_bundle_packer_if.slave bus
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [31:0]   ADDR_TOP = 32'(INST_MEM_SIZE - 1);

    slots_t           slot_q, slot_d, slot_n, cl_slots;
    occ_t             occ_q, occ_d, occ_n, cl_occ;
    logic [WW-1:0]    wait_q, wait_d;
    logic             pkt_valid_q;
    logic [PKT_W-1:0] pkt_data_q;
    logic [31:0]      pkt_addr_q;
    logic             err_q;

    logic       in_ready, acc, ins, hit, close, hs;
    logic       legal;
    logic [2:0] cls;

    vliw_slot_classifier u_cls (
        .opc_i   (bus.in_data[31:27]),
        .legal_o (legal),
        .slot_o  (cls)
    );

    assign in_ready = !pkt_valid_q || bus.pkt_ready;
    assign acc      = bus.in_valid && in_ready;
    assign ins      = acc && legal;
    assign hit      = ins && occ_q[cls];
    assign hs       = pkt_valid_q && bus.pkt_ready;

    // Slot accumulation and bundle-close decision
    always_comb begin
        slot_n   = slot_q;
        occ_n    = occ_q;
        slot_d   = slot_q;
        occ_d    = occ_q;
        cl_slots = slot_q;
        cl_occ   = occ_q;
        close    = 1'b0;
        if (in_ready) begin
            if (hit) begin
                // Slot conflict: old bundle leaves, new one starts
                close       = 1'b1;
                occ_d       = occ_t'(1) << cls;
                slot_d[cls] = bus.in_data;
            end else begin
                if (ins) begin
                    occ_n[cls]  = 1'b1;
                    slot_n[cls] = bus.in_data;
                end
                slot_d   = slot_n;
                occ_d    = occ_n;
                cl_slots = slot_n;
                cl_occ   = occ_n;
                if (occ_n != '0 &&
                    (occ_n == '1 || bus.flush || wait_q == WAIT_MAX)) begin
                    close = 1'b1;
                    occ_d = '0;
                end
            end
        end
    end

    // Age of the open bundle; keeps counting while the output is stalled
    always_comb begin
        if (close || occ_q == '0) begin
            wait_d = '0;
        end else if (wait_q == WAIT_MAX) begin
            wait_d = wait_q;
        end else begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Accumulator, output register and address counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q      <= '0;
            occ_q       <= '0;
            wait_q      <= '0;
            pkt_valid_q <= 1'b0;
            pkt_data_q  <= '0;
            pkt_addr_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            slot_q <= slot_d;
            occ_q  <= occ_d;
            wait_q <= wait_d;
            err_q  <= acc && !legal;
            if (hs) begin
                pkt_addr_q <= (pkt_addr_q == ADDR_TOP) ? '0 : pkt_addr_q + 1'b1;
            end
            if (close) begin
                pkt_valid_q <= 1'b1;
                pkt_data_q  <= pack_bundle(cl_slots, cl_occ);
            end else if (hs) begin
                pkt_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.pkt_valid   = pkt_valid_q;
    assign bus.pkt_data    = pkt_data_q;
    assign bus.pkt_addr    = pkt_addr_q;
    assign bus.err_illegal = err_q;

endmodule
